// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / bubble / flush sequencing for the 5-stage RISC-V pipeline, with a
// data-memory watchdog. Define HAZARD_STATS_EN to build the stall/flush statistics counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegisterRd,
    input  logic [4:0]       IF_ID_RegisterRs1,
    input  logic [4:0]       IF_ID_RegisterRs2,
    input  logic             Branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_Flush,
    output logic             ID_Flush_lwstall,
    output logic             Pipe_Freeze,
    output logic             mem_timeout,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_LWSTALL = 2'd1;
    localparam logic [1:0] ST_MEMWAIT = 2'd2;
    localparam logic [1:0] ST_ERR     = 2'd3;

    localparam int         TIMEOUT_LAST_I = MEM_TIMEOUT - 1;
    localparam logic [7:0] TIMEOUT_LAST   = TIMEOUT_LAST_I[7:0];

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;
    logic       timeout_q;
    logic       timeout_d;

    logic       freeze_s;
    logic       load_use_s;
    logic       rd_match_s;
    logic       wd_expire_s;

    assign freeze_s    = mem_req & ~mem_ready;
    assign rd_match_s  = (ID_EX_RegisterRd == IF_ID_RegisterRs1) |
                         (ID_EX_RegisterRd == IF_ID_RegisterRs2);
    assign load_use_s  = ID_EX_MemRead & (ID_EX_RegisterRd != 5'd0) & rd_match_s;
    // The entry freeze cycle is counted too, so ERR lands on the edge ending the
    // MEM_TIMEOUT-th consecutive freeze cycle.
    assign wd_expire_s = freeze_s & (wait_cnt_q == TIMEOUT_LAST);

    // Mealy pipeline controls: ERR/freeze > load-use bubble > taken-branch flush > run.
    always_comb begin
        PC_Write         = 1'b1;
        IF_ID_Write      = 1'b1;
        IF_Flush         = 1'b0;
        ID_Flush_lwstall = 1'b0;
        Pipe_Freeze      = 1'b0;
        if ((state_q == ST_ERR) || freeze_s) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            Pipe_Freeze = 1'b1;
        end else if (load_use_s && (state_q != ST_LWSTALL)) begin
            PC_Write         = 1'b0;
            IF_ID_Write      = 1'b0;
            ID_Flush_lwstall = 1'b1;
        end else if (Branch_taken) begin
            IF_Flush = 1'b1;
        end else begin
            PC_Write    = 1'b1;
            IF_ID_Write = 1'b1;
        end
    end

    // FSM next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (freeze_s) begin
                    state_d = wd_expire_s ? ST_ERR : ST_MEMWAIT;
                end else if (load_use_s) begin
                    state_d = ST_LWSTALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LWSTALL: begin
                if (freeze_s) begin
                    state_d = wd_expire_s ? ST_ERR : ST_MEMWAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEMWAIT: begin
                if (freeze_s) begin
                    state_d = wd_expire_s ? ST_ERR : ST_MEMWAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Watchdog count runs only while the next state is MEMWAIT; ERR is sticky by construction.
    always_comb begin
        wait_cnt_d = 8'd0;
        timeout_d  = 1'b0;
        if (state_d == ST_MEMWAIT) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d = 8'd0;
        end
        if (state_d == ST_ERR) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = 1'b0;
        end
    end

    // State, watchdog counter and error flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign ctrl_state  = state_q;
    assign mem_timeout = timeout_q;

`ifdef HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Saturating statistics: stalled PC cycles and bubble/flush cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!PC_Write) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (IF_Flush || ID_Flush_lwstall) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`else
    assign stall_cycles = {CNT_W{1'b0}};
    assign flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core: sequences stalls, bubbles and flushes across the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards, squashes wrong-path fetches on taken branches, and freezes the whole pipeline while a multi-cycle data-memory access is outstanding. A memory watchdog locks the pipeline into an error state if the memory never responds. Its `ID_Flush_lwstall` output drives the ID/EX register's control-clear input.

## Interface
Parameters:
- `MEM_TIMEOUT`, 15: wait cycles tolerated before error; legal range 1..255.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ID_EX_MemRead` in 1: instruction in EX is a load.
- `ID_EX_RegisterRd` in 5: destination register of the instruction in EX.
- `IF_ID_RegisterRs1`, `IF_ID_RegisterRs2` in 5 each: source registers of the instruction in ID.
- `Branch_taken` in 1: branch resolved taken in ID this cycle.
- `mem_req` in 1: MEM stage holds a load or store.
- `mem_ready` in 1: data memory completes the access this cycle.
- `PC_Write` out 1: PC update enable.
- `IF_ID_Write` out 1: IF/ID load enable.
- `IF_Flush` out 1: clears IF/ID to a NOP.
- `ID_Flush_lwstall` out 1: clears ID/EX control bits, inserting a bubble.
- `Pipe_Freeze` out 1: holds ID/EX, EX/MEM and MEM/WB.
- `mem_timeout` out 1: sticky watchdog error.
- `ctrl_state` out 2: FSM state, for debug.
- `stall_cycles` out `CNT_W`: stall statistics counter.
- `flush_count` out `CNT_W`: flush statistics counter.

## Operation
- **Combinational hazard terms**
  - `freeze = mem_req & ~mem_ready`
  - `load_use = ID_EX_MemRead & (ID_EX_RegisterRd != 0) & (ID_EX_RegisterRd == IF_ID_RegisterRs1 | ID_EX_RegisterRd == IF_ID_RegisterRs2)`
- **Output priority** (outputs are Mealy on state and inputs):
  1. State ERR: `Pipe_Freeze=1`, `PC_Write=0`, `IF_ID_Write=0`, `IF_Flush=0`, `ID_Flush_lwstall=0`.
  2. `freeze`: same output values as ERR.
  3. `load_use` and state != LWSTALL: `PC_Write=0`, `IF_ID_Write=0`, `ID_Flush_lwstall=1`. `Branch_taken` is ignored.
  4. `Branch_taken`: `IF_Flush=1`, `PC_Write=1`, `IF_ID_Write=1`.
  5. Otherwise: `PC_Write=1`, `IF_ID_Write=1`, all other outputs 0.
- **FSM states** (encoding): RUN=0, LWSTALL=1, MEMWAIT=2, ERR=3.
  - RUN: go to MEMWAIT if `freeze`; else go to LWSTALL if `load_use`; else stay in RUN.
  - LWSTALL: go to MEMWAIT if `freeze`; else go to RUN. `load_use` is masked in this state, which limits a bubble to exactly one cycle per load.
  - MEMWAIT: `wait_cnt` increments each `freeze` cycle. Go to RUN when `mem_ready`, clearing `wait_cnt`. Go to ERR when `freeze` holds and `wait_cnt == MEM_TIMEOUT-1`.
  - ERR: absorbing state; sets `mem_timeout=1`. Only `reset_n` exits it.
- **Watchdog counter:** `wait_cnt` is 8 bits wide and cleared on every exit from MEMWAIT.
- **Simultaneous events:**
  - `freeze` together with `load_use` or `Branch_taken`: freeze wins. The hazard is re-evaluated on the first unfrozen cycle, because IF/ID and ID/EX are held.
  - `mem_ready` on the cycle that would reach timeout: completion wins; next state is RUN.

## Timing
- **Reset values** (`reset_n` low, asynchronous): state=RUN, `wait_cnt=0`, `mem_timeout=0`, `stall_cycles=0`, `flush_count=0`. Combinational outputs then follow the priority list. With all inputs 0: `PC_Write=1`, `IF_ID_Write=1`, other outputs 0.
- **Latency:** hazard responses are combinational, in the same cycle as detection. `mem_timeout` and `ctrl_state` are registered, one cycle after the triggering edge.
- **Load-use:** exactly 1 bubble cycle. The dependent instruction issues on the following cycle.
- **Memory freeze:** lasts N cycles for N low cycles of `mem_ready` while `mem_req` is high.
- **Watchdog:** ERR is entered on the edge ending the `MEM_TIMEOUT`-th consecutive `freeze` cycle.
- **Reset mid-operation:** asserting `reset_n` low during MEMWAIT or ERR returns to RUN immediately and clears `wait_cnt` and `mem_timeout`.

## Configuration
- **`HAZARD_STATS_EN` defined:**
  - `stall_cycles` increments on every cycle with `PC_Write=0`.
  - `flush_count` increments on every cycle with `IF_Flush=1` or `ID_Flush_lwstall=1`.
  - Both counters saturate at all-ones and are cleared by reset.
- **`HAZARD_STATS_EN` undefined:** the counter logic is not compiled; `stall_cycles` and `flush_count` are driven constant 0. The ports remain in both builds.

## Test plan
- **Load-use:** `ID_EX_MemRead=1`, `Rd=5`, `Rs1=5` for 2 cycles → cycle 1: `PC_Write=0`, `ID_Flush_lwstall=1`, next state LWSTALL; cycle 2: `PC_Write=1`, `ID_Flush_lwstall=0`. With `Rd=0`, no stall.
- **Branch:** `Branch_taken=1` with no other hazard → `IF_Flush=1`, `PC_Write=1` for that cycle only. With `load_use` also high → only `ID_Flush_lwstall=1`, `IF_Flush=0`.
- **Memory wait:** `mem_req=1`, `mem_ready=0` for 3 cycles, then `mem_ready=1` → `Pipe_Freeze=1` for 3 cycles, `ctrl_state=2`, then RUN. `stall_cycles=3` with stats enabled.
- **Watchdog:** `MEM_TIMEOUT=4`, `mem_ready` held 0 → `mem_timeout=1`, `ctrl_state=3` after the 4th freeze cycle. Stays set when `mem_ready=1` is applied later. Clears on `reset_n=0`.
- **Freeze vs. load-use:** `freeze` and `load_use` asserted together → no bubble during the freeze. The bubble is issued on the first cycle after `mem_ready`.
- **Saturation:** with `CNT_W=4` and stats enabled, 20 stall cycles → `stall_cycles=15`. Without the macro, both counters read 0.
